// File: rtl/i2c_reg_slave.sv
// I2C/SCCB target with an internal byte register file, 8/16-bit register addressing.
// Define I2C_REG_SLAVE_AUTOINC_EN to auto-increment the register pointer after each data byte.
//
// state   | meaning
// IDLE    | waiting for START (also parks here after a read NACK until STOP)
// DEV     | shifting in device address + R/W
// ACK_DEV | driving ACK for our device address
// AH      | shifting in register address high byte (16-bit mode only)
// ACK_AH  | driving ACK for address high byte
// AL      | shifting in register address low byte
// ACK_AL  | driving ACK for address low byte
// WDATA   | shifting in a write data byte
// ACK_W   | driving ACK for a write data byte
// RDATA   | driving a read byte MSB first
// MACK    | sampling master ACK/NACK after a read byte
module i2c_reg_slave #(
  parameter logic [7:0] DEV_ADDR    = 8'h78,
  parameter int         AW          = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        addr_mode,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic        wr_stb,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic [7:0]  nack_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_ACK_DEV, S_AH, S_ACK_AH, S_AL, S_ACK_AL,
    S_WDATA, S_ACK_W, S_RDATA, S_MACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic [15:0] pointer_q, pointer_d;
  logic [7:0]  tx_q, tx_d;
  logic        sda_oe_q, sda_oe_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic [7:0]  nack_q, nack_d;
  logic        wr_stb_q, wr_stb_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic [7:0]  regfile [0:(1<<AW)-1];
  logic [15:0] ptr_step;
  logic [7:0]  rd_byte, rd_byte_next;

  // Sync flops reset to 1 so an idle bus produces no spurious edges after reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_sclk};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sdat};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & ~sda_s & sda_q;
  assign stop_det  = scl_s & scl_q & sda_s & ~sda_q;

`ifdef I2C_REG_SLAVE_AUTOINC_EN
  assign ptr_step = pointer_q + 16'd1;
`else
  assign ptr_step = pointer_q;
`endif

  assign rd_byte      = regfile[pointer_q[AW-1:0]];
  assign rd_byte_next = regfile[ptr_step[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (wr_stb_d) regfile[pointer_q[AW-1:0]] <= wr_data_d;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'h00;
      addr_hi_q <= 8'h00;
      pointer_q <= 16'h0000;
      tx_q      <= 8'h00;
      sda_oe_q  <= 1'b0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      nack_q    <= 8'h00;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 16'h0000;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      addr_hi_q <= addr_hi_d;
      pointer_q <= pointer_d;
      tx_q      <= tx_d;
      sda_oe_q  <= sda_oe_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      nack_q    <= nack_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    addr_hi_d = addr_hi_q;
    pointer_d = pointer_q;
    tx_d      = tx_q;
    sda_oe_d  = sda_oe_q;
    rw_d      = rw_q;
    busy_d    = busy_q;
    nack_d    = nack_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d   = S_DEV;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_DEV, S_AH, S_AL, S_WDATA: begin
          // Bits shift in on SCL rise; the byte is acted on at the following fall.
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (state_q == S_WDATA && bit_cnt_q == 4'd7) begin
              wr_stb_d  = 1'b1;
              wr_addr_d = pointer_q;
              wr_data_d = {shreg_q[6:0], sda_s};
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            case (state_q)
              S_DEV: begin
                if (shreg_q[7:1] == DEV_ADDR[7:1]) begin
                  state_d  = S_ACK_DEV;
                  sda_oe_d = 1'b1;
                  rw_d     = shreg_q[0];
                  busy_d   = 1'b1;
                end else begin
                  state_d = S_IDLE;
                end
              end
              S_AH: begin
                addr_hi_d = shreg_q;
                state_d   = S_ACK_AH;
                sda_oe_d  = 1'b1;
              end
              S_AL: begin
                pointer_d = addr_mode ? {addr_hi_q, shreg_q} : {8'h00, shreg_q};
                state_d   = S_ACK_AL;
                sda_oe_d  = 1'b1;
              end
              default: begin
                state_d  = S_ACK_W;
                sda_oe_d = 1'b1;
              end
            endcase
          end
        end
        S_ACK_DEV: begin
          if (scl_fall) begin
            if (rw_q) begin
              tx_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = S_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = addr_mode ? S_AH : S_AL;
            end
          end
        end
        S_ACK_AH: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_AL;
          end
        end
        S_ACK_AL: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_WDATA;
          end
        end
        S_ACK_W: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            pointer_d = ptr_step;
            state_d   = S_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_MACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              tx_d      = {tx_q[6:0], 1'b0};
              sda_oe_d  = ~tx_q[6];
            end
          end
        end
        S_MACK: begin
          // A NACK leaves on the rise, so any fall seen here follows an ACK.
          if (scl_rise && sda_s) begin
            nack_d  = (nack_q == 8'hFF) ? nack_q : nack_q + 8'd1;
            state_d = S_IDLE;
          end else if (scl_fall) begin
            pointer_d = ptr_step;
            tx_d      = rd_byte_next;
            sda_oe_d  = ~rd_byte_next[7];
            state_d   = S_RDATA;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign nack_cnt = nack_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C master tasks plus per-scenario checks.
`timescale 1ns/1ps
module tb_i2c_reg_slave;
  localparam time Q = 100ns;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        addr_mode;
  logic        scl;
  logic        m_low;
  wire         i2c_sdat;
  logic        wr_stb;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic [7:0]  nack_cnt;

  int chk_total = 0;
  int chk_pass  = 0;
  int stb_cnt   = 0;
  logic busy_seen  = 1'b0;
  logic slave_low  = 1'b0;

  assign i2c_sdat = m_low ? 1'b0 : 1'bz;
  pullup (i2c_sdat);

  always #5 Clk = ~Clk;

  i2c_reg_slave dut (
    .Clk(Clk), .Rst_n(Rst_n), .addr_mode(addr_mode), .i2c_sclk(scl), .i2c_sdat(i2c_sdat),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .nack_cnt(nack_cnt)
  );

  always @(negedge Clk) begin
    if (wr_stb) stb_cnt++;
    if (busy) busy_seen = 1'b1;
    if (i2c_sdat === 1'b0 && !m_low) slave_low = 1'b1;
  end

  task automatic bus_start();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #(2*Q);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = i2c_sdat; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic test_reset();
    chk_total++; if (wr_stb !== 1'b0) $display("FAIL reset_wr_stb got %b want 0", wr_stb); else chk_pass++;
    chk_total++; if (wr_addr !== 16'h0000) $display("FAIL reset_wr_addr got %h want 0000", wr_addr); else chk_pass++;
    chk_total++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data got %h want 00", wr_data); else chk_pass++;
    chk_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else chk_pass++;
    chk_total++; if (nack_cnt !== 8'h00) $display("FAIL reset_nack_cnt got %h want 00", nack_cnt); else chk_pass++;
    chk_total++; if (i2c_sdat !== 1'b1) $display("FAIL reset_sda got %b want 1", i2c_sdat); else chk_pass++;
  endtask

  task automatic test_write16();
    logic a0, a1, a2, a3;
    int   s0;
    addr_mode = 1'b1;
    s0 = stb_cnt;
    bus_start();
    send_byte(8'h78, a0);
    chk_total++; if (busy !== 1'b1) $display("FAIL w16_busy_in got %b want 1", busy); else chk_pass++;
    send_byte(8'h30, a1);
    send_byte(8'h08, a2);
    send_byte(8'h82, a3);
    bus_stop();
    chk_total++; if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL w16_acks got %b want 0000", {a0, a1, a2, a3}); else chk_pass++;
    chk_total++; if (stb_cnt - s0 != 1) $display("FAIL w16_stb_count got %0d want 1", stb_cnt - s0); else chk_pass++;
    chk_total++; if (wr_addr !== 16'h3008) $display("FAIL w16_wr_addr got %h want 3008", wr_addr); else chk_pass++;
    chk_total++; if (wr_data !== 8'h82) $display("FAIL w16_wr_data got %h want 82", wr_data); else chk_pass++;
    chk_total++; if (busy !== 1'b0) $display("FAIL w16_busy_after_stop got %b want 0", busy); else chk_pass++;
  endtask

  task automatic test_read16();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    addr_mode = 1'b1;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h30, a1);
    send_byte(8'h08, a2);
    bus_start();
    send_byte(8'h79, a3);
    recv_byte(1'b1, d);
    bus_stop();
    chk_total++; if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL r16_acks got %b want 0000", {a0, a1, a2, a3}); else chk_pass++;
    chk_total++; if (d !== 8'h82) $display("FAIL r16_data got %h want 82", d); else chk_pass++;
    chk_total++; if (nack_cnt !== 8'h01) $display("FAIL r16_nack_cnt got %h want 01", nack_cnt); else chk_pass++;
  endtask

  task automatic test_read8();
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] d;
    addr_mode = 1'b0;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h12, a1);
    send_byte(8'h5A, a2);
    bus_stop();
    chk_total++; if (wr_addr !== 16'h0012) $display("FAIL r8_wr_addr got %h want 0012", wr_addr); else chk_pass++;
    bus_start();
    send_byte(8'h78, a3);
    send_byte(8'h12, a4);
    bus_stop();
    bus_start();
    send_byte(8'h79, a5);
    recv_byte(1'b1, d);
    bus_stop();
    chk_total++; if ({a0, a1, a2, a3, a4, a5} !== 6'b0) $display("FAIL r8_acks got %b want 000000", {a0, a1, a2, a3, a4, a5}); else chk_pass++;
    chk_total++; if (d !== 8'h5A) $display("FAIL r8_data got %h want 5a", d); else chk_pass++;
    chk_total++; if (nack_cnt !== 8'h02) $display("FAIL r8_nack_cnt got %h want 02", nack_cnt); else chk_pass++;
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int   s0;
    addr_mode = 1'b0;
    s0 = stb_cnt;
    busy_seen = 1'b0;
    slave_low = 1'b0;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h55, a1);
    bus_stop();
    chk_total++; if ({a0, a1} !== 2'b11) $display("FAIL badaddr_acks got %b want 11", {a0, a1}); else chk_pass++;
    chk_total++; if (slave_low !== 1'b0) $display("FAIL badaddr_sda_driven got %b want 0", slave_low); else chk_pass++;
    chk_total++; if (stb_cnt - s0 != 0) $display("FAIL badaddr_stb got %0d want 0", stb_cnt - s0); else chk_pass++;
    chk_total++; if (busy_seen !== 1'b0) $display("FAIL badaddr_busy got %b want 0", busy_seen); else chk_pass++;
  endtask

  task automatic test_burst();
    logic a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10;
    logic [7:0] d0, d1, d2;
    logic [7:0] e0, e1, e2;
    logic [15:0] last_addr;
    int   s0;
`ifdef I2C_REG_SLAVE_AUTOINC_EN
    e0 = 8'h11; e1 = 8'h22; e2 = 8'h33; last_addr = 16'h0100;
`else
    e0 = 8'h33; e1 = 8'h33; e2 = 8'h33; last_addr = 16'h00FE;
`endif
    addr_mode = 1'b1;
    s0 = stb_cnt;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h00, a1);
    send_byte(8'hFE, a2);
    send_byte(8'h11, a3);
    send_byte(8'h22, a4);
    send_byte(8'h33, a5);
    bus_stop();
    chk_total++; if (stb_cnt - s0 != 3) $display("FAIL burst_stb got %0d want 3", stb_cnt - s0); else chk_pass++;
    chk_total++; if (wr_addr !== last_addr) $display("FAIL burst_last_addr got %h want %h", wr_addr, last_addr); else chk_pass++;
    bus_start();
    send_byte(8'h78, a6);
    send_byte(8'h00, a7);
    send_byte(8'hFE, a8);
    bus_start();
    send_byte(8'h79, a9);
    recv_byte(1'b0, d0);
    recv_byte(1'b0, d1);
    recv_byte(1'b1, d2);
    bus_stop();
    a10 = 1'b0;
    chk_total++; if ({a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10} !== 11'b0) $display("FAIL burst_acks got %b", {a0, a1, a2, a3, a4, a5, a6, a7, a8, a9}); else chk_pass++;
    chk_total++; if ({d0, d1, d2} !== {e0, e1, e2}) $display("FAIL burst_read got %h want %h", {d0, d1, d2}, {e0, e1, e2}); else chk_pass++;
    chk_total++; if (nack_cnt !== 8'h03) $display("FAIL burst_nack_cnt got %h want 03", nack_cnt); else chk_pass++;
  endtask

  task automatic test_abort();
    logic a0, a1, a2;
    int   s0;
    addr_mode = 1'b0;
    s0 = stb_cnt;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h20, a1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_start();
    send_byte(8'h78, a2);
    bus_stop();
    chk_total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL abort_acks got %b want 000", {a0, a1, a2}); else chk_pass++;
    chk_total++; if (stb_cnt - s0 != 0) $display("FAIL abort_stb got %0d want 0", stb_cnt - s0); else chk_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic a0, a1, a2;
    addr_mode = 1'b0;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h12, a1);
    bus_start();
    send_byte(8'h79, a2);
    chk_total++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rstrd_acks got %b want 000", {a0, a1, a2}); else chk_pass++;
    chk_total++; if (i2c_sdat !== 1'b0) $display("FAIL rstrd_msb_driven got %b want 0", i2c_sdat); else chk_pass++;
    Rst_n = 1'b0;
    #1;
    chk_total++; if (i2c_sdat !== 1'b1) $display("FAIL rstrd_sda_released got %b want 1", i2c_sdat); else chk_pass++;
    chk_total++; if (busy !== 1'b0) $display("FAIL rstrd_busy got %b want 0", busy); else chk_pass++;
    chk_total++; if (nack_cnt !== 8'h00) $display("FAIL rstrd_nack_cnt got %h want 00", nack_cnt); else chk_pass++;
    #Q;
    scl = 1'b1;
    m_low = 1'b0;
    #Q;
    Rst_n = 1'b1;
    #(2*Q);
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2, a3, a4, a5;
    logic [7:0] d;
    addr_mode = 1'b0;
    bus_start();
    send_byte(8'h78, a0);
    send_byte(8'h40, a1);
    send_byte(8'h34, a2);
    bus_stop();
    chk_total++; if (wr_addr !== 16'h0040 || wr_data !== 8'h34) $display("FAIL b2b_commit got %h/%h want 0040/34", wr_addr, wr_data); else chk_pass++;
    bus_start();
    send_byte(8'h78, a3);
    send_byte(8'h40, a4);
    bus_start();
    send_byte(8'h79, a5);
    recv_byte(1'b1, d);
    bus_stop();
    chk_total++; if ({a0, a1, a2, a3, a4, a5} !== 6'b0) $display("FAIL b2b_acks got %b want 000000", {a0, a1, a2, a3, a4, a5}); else chk_pass++;
    chk_total++; if (d !== 8'h34) $display("FAIL b2b_data got %h want 34", d); else chk_pass++;
  endtask

  initial begin
    Rst_n = 1'b0;
    addr_mode = 1'b0;
    scl = 1'b1;
    m_low = 1'b0;
    #55;
    Rst_n = 1'b1;
    #Q;
    test_reset();
    test_write16();
    test_read16();
    test_read8();
    test_wrong_addr();
    test_burst();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
